ga_chrom_queue: RTL and testbench

- Chromosome FIFO at the receiving end of the mutation stage's push interface (queue_push / queue_chromosome).
- The push side has no backpressure, so the queue reports full and overflow status instead of stalling the producer.
- Stored chromosomes are served to the downstream consumer (fitness/selection) over a valid/ack handshake, in the same style as child_valid/child_ack.
- Counts accepted pushes against the configured population size and pulses gen_complete once a generation is fully enqueued.

---
 rtl/ga_chrom_queue.sv | 122 ++++++++++++
 tb/tb_ga_chrom_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ga_chrom_queue.sv
// ga_chrom_queue
// Chromosome FIFO fed by the mutation stage's push interface and drained by
// the fitness/selection consumer.
//
// Handshakes:
//   push side : queue_push is a strobe with no backpressure. A push is taken
//               when the queue is not full, or when it is full and a pop
//               happens in the same cycle. Any other push is dropped and
//               overflow_err latches high until reset.
//   pop side  : chrom_valid/chrom present the head entry. The consumer pops
//               by raising chrom_ack while chrom_valid=1. chrom_ack while
//               chrom_valid=0 is ignored. The head is held stable until it
//               is acked.
//
// Ports:
//   clk, rstn          clock (rising edge), async active-low reset
//   sw_rst             synchronous reset, same effect as rstn
//   cnfg_pop_size      chromosomes per generation (1..2^POP_MAX_W-1)
//   queue_push         push strobe
//   queue_chromosome   push data
//   queue_full         occupancy == DEPTH
//   queue_cnt          occupancy 0..DEPTH
//   overflow_err       sticky dropped-push flag
//   chrom_valid        head entry available
//   chrom              head entry data (0 while empty)
//   chrom_ack          consumer pop
//   gen_complete       one-cycle pulse after the push that completes a generation
module ga_chrom_queue #(
  parameter int CHROM_MAX_W = 64,
  parameter int DEPTH       = 8,
  parameter int POP_MAX_W   = 8,
  parameter int SIM_DLY     = 1,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  input  logic [POP_MAX_W-1:0]   cnfg_pop_size,
  input  logic                   queue_push,
  input  logic [CHROM_MAX_W-1:0] queue_chromosome,
  output logic                   queue_full,
  output logic [PTR_W:0]         queue_cnt,
  output logic                   overflow_err,
  output logic                   chrom_valid,
  output logic [CHROM_MAX_W-1:0] chrom,
  input  logic                   chrom_ack,
  output logic                   gen_complete
);

  // SIM_DLY only exists for interface compatibility with delay-annotated
  // models; this synthesizable description applies no assignment delays.
  if (SIM_DLY < 0) begin : g_sim_dly_unused
  end

  logic [CHROM_MAX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic [POP_MAX_W-1:0]   r_pcnt;
  logic                   r_ovf;
  logic                   r_gen;

  logic w_pop_en;
  logic w_push_acc;
  logic w_full;
  logic w_valid;

  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_pop_en   = chrom_ack & w_valid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_acc = queue_push & (~w_full | w_pop_en);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pcnt   <= '0;
      r_ovf    <= 1'b0;
      r_gen    <= 1'b0;
    end else if (sw_rst) begin
      // Any push or pop presented alongside sw_rst is discarded.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pcnt   <= '0;
      r_ovf    <= 1'b0;
      r_gen    <= 1'b0;
    end else begin
      // Pointer width equals log2(DEPTH), so the increment wraps naturally.
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push_acc) - (PTR_W+1)'(w_pop_en);

      if (queue_push && !w_push_acc) r_ovf <= 1'b1;

      r_gen <= 1'b0;
      if (w_push_acc) begin
        if (r_pcnt == cnfg_pop_size - POP_MAX_W'(1)) begin
          r_gen  <= 1'b1;
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
    end
  end

  // Storage is not reset; chrom is masked to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push_acc && !sw_rst) r_mem[r_wr_ptr] <= queue_chromosome;
  end

  assign queue_full   = w_full;
  assign queue_cnt    = r_count;
  assign overflow_err = r_ovf;
  assign chrom_valid  = w_valid;
  assign chrom        = w_valid ? r_mem[r_rd_ptr] : '0;
  assign gen_complete = r_gen;

endmodule

// File: tb/tb_ga_chrom_queue.sv
module tb_ga_chrom_queue;

  localparam int W     = 64;
  localparam int DEPTH = 8;
  localparam int PW    = 8;

  logic          clk;
  logic          rstn;
  logic          sw_rst;
  logic [PW-1:0] cnfg_pop_size;
  logic          queue_push;
  logic [W-1:0]  queue_chromosome;
  logic          queue_full;
  logic [3:0]    queue_cnt;
  logic          overflow_err;
  logic          chrom_valid;
  logic [W-1:0]  chrom;
  logic          chrom_ack;
  logic          gen_complete;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue contents themselves plus a generation counter.
  logic [W-1:0] exp_q[$];
  int           m_pcnt;
  logic         m_ovf;
  logic         m_gen;
  int           gen_seen;

  ga_chrom_queue #(.CHROM_MAX_W(W), .DEPTH(DEPTH), .POP_MAX_W(PW), .SIM_DLY(1)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .cnfg_pop_size(cnfg_pop_size),
    .queue_push(queue_push), .queue_chromosome(queue_chromosome),
    .queue_full(queue_full), .queue_cnt(queue_cnt), .overflow_err(overflow_err),
    .chrom_valid(chrom_valid), .chrom(chrom), .chrom_ack(chrom_ack),
    .gen_complete(gen_complete)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pcnt = 0;
    m_ovf  = 1'b0;
    m_gen  = 1'b0;
  endtask

  // Model step + monitor: inputs change only at negedge, so they are stable
  // here. After the edge settles, every DUT output is compared to the model.
  always @(posedge clk) begin
    logic pop, acc;
    if (!rstn || sw_rst) begin
      model_clear();
    end else begin
      pop = chrom_ack && (exp_q.size() != 0);
      acc = queue_push && ((exp_q.size() < DEPTH) || pop);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(queue_chromosome);
      if (queue_push && !acc) m_ovf = 1'b1;
      m_gen = 1'b0;
      if (acc) begin
        if (m_pcnt + 1 == int'(cnfg_pop_size)) begin
          m_gen = 1'b1;
          m_pcnt = 0;
        end else begin
          m_pcnt++;
        end
      end
    end
    #2;
    chk("queue_cnt",    W'(queue_cnt),    W'(exp_q.size()));
    chk("queue_full",   W'(queue_full),   W'(exp_q.size() == DEPTH));
    chk("chrom_valid",  W'(chrom_valid),  W'(exp_q.size() != 0));
    chk("chrom",        chrom,            (exp_q.size() != 0) ? exp_q[0] : '0);
    chk("overflow_err", W'(overflow_err), W'(m_ovf));
    chk("gen_complete", W'(gen_complete), W'(m_gen));
    if (gen_complete) gen_seen++;
  end

  // Driver
  task automatic cyc(input logic p, input logic [W-1:0] d, input logic a, input logic s);
    @(negedge clk);
    queue_push       = p;
    queue_chromosome = d;
    chrom_ack        = a;
    sw_rst           = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [W-1:0] b;
    rstn = 1'b0; sw_rst = 1'b0; queue_push = 1'b0; chrom_ack = 1'b0;
    queue_chromosome = '0; cnfg_pop_size = 8'd5;
    model_clear();
    gen_seen = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(1);

    // Ordered transfer
    cyc(1, 64'hA1, 0, 0); cyc(1, 64'hA2, 0, 0); cyc(1, 64'hA3, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    idle(1);

    // Async reset mid-cycle with three entries queued
    cyc(1, rnd64(), 0, 0); cyc(1, rnd64(), 0, 0); cyc(1, rnd64(), 0, 0);
    idle(1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst queue_cnt",    W'(queue_cnt),    '0);
    chk("rst chrom_valid",  W'(chrom_valid),  '0);
    chk("rst chrom",        chrom,            '0);
    chk("rst overflow_err", W'(overflow_err), '0);
    chk("rst gen_complete", W'(gen_complete), '0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    idle(1);

    // Overflow: nine pushes, ninth dropped, then drain
    for (int i = 1; i <= 9; i++) cyc(1, W'(i), 0, 0);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);
    idle(1);

    // Full with simultaneous push and pop
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, W'(16 + i), 0, 0);
    b = 64'hB0B0_B0B0_0000_000B;
    cyc(1, b, 1, 0);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);
    idle(1);

    // Generation pulse with pointer wrap
    cyc(0, '0, 0, 1);
    cnfg_pop_size = 8'd5;
    gen_seen = 0;
    for (int i = 0; i < 12; i++) cyc(1, rnd64(), (i % 2) == 1, 0);
    idle(2);
    chk("gen pulses in 12 pushes", W'(gen_seen), W'(2));
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);

    // sw_rst with four entries; push alongside sw_rst is ignored
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, rnd64(), 0, 0);
    cyc(1, rnd64(), 1, 1);
    gen_seen = 0;
    for (int i = 0; i < 5; i++) cyc(1, rnd64(), 1, 0);
    idle(2);
    chk("gen after sw_rst", W'(gen_seen), W'(1));
    idle(2);
    // Stray acks while empty
    cyc(0, '0, 1, 0); cyc(0, '0, 1, 0);
    idle(1);

    // pop_size = 1
    cnfg_pop_size = 8'd1;
    cyc(0, '0, 0, 1);
    gen_seen = 0;
    for (int i = 0; i < 4; i++) cyc(1, rnd64(), 1, 0);
    idle(2);
    chk("gen every push", W'(gen_seen), W'(4));

    // Randomized traffic
    for (int r = 0; r < 4; r++) begin
      cnfg_pop_size = PW'($urandom_range(1, 7));
      cyc(0, '0, 0, 1);
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 99) < 60, rnd64(), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 2);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
